// File: rtl/sprite_arb_pkg.sv
// Shared defaults and types for the sprite ROM arbiter: the requester count,
// ROM geometry and the requester-index type.
package sprite_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int ADDR_W_DEF  = 19;
  localparam int DATA_W_DEF  = 3;
  localparam int ROM_LAT_DEF = 1;

  localparam int REQ_IDX_W = (N_REQ_DEF > 1) ? $clog2(N_REQ_DEF) : 1;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: the first asserted request at or above ptr,
// wrapping to 0. Produces a one-hot grant, its index, and an any-grant flag.
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_gnt
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N_REQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    sum     = '0;
    cand    = '0;
    // Modular walk from ptr without a divider; ptr is always below N_REQ.
    for (int k = 0; k < N_REQ; k++) begin
      sum  = {1'b0, ptr} + (IDX_W+1)'(k);
      cand = (sum >= N_EXT) ? IDX_W'(sum - N_EXT) : IDX_W'(sum);
      if (!any_gnt && req[cand]) begin
        any_gnt   = 1'b1;
        gnt_idx   = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM between several requesters.
// One grant per cycle; a tag pipeline routes each ROM result back in grant order.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic                    vga_clk,
  input  logic                    Reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_address,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [DATA_W-1:0]       rdata,
  output logic [N_REQ-1:0]        rvalid,
  output logic                    busy
);

  localparam int               IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  gnt_idx;
  logic              any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [ROM_LAT-1:0] tag_vld_p;
  logic [IDX_W-1:0]  tag_idx_p [ROM_LAT];

  function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
  endfunction

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) sel_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Grant stage: advance the round-robin pointer and launch the ROM address
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      ptr         <= '0;
      rom_address <= '0;
    end else if (any_gnt) begin
      ptr         <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
      rom_address <= sel_addr;
    end
  end

  // Tag stages p0..p(ROM_LAT-1): follow the ROM read latency
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      tag_vld_p <= '0;
      for (int k = 0; k < ROM_LAT; k++) tag_idx_p[k] <= '0;
    end else begin
      tag_vld_p[0] <= any_gnt;
      tag_idx_p[0] <= gnt_idx;
      for (int k = 1; k < ROM_LAT; k++) begin
        tag_vld_p[k] <= tag_vld_p[k-1];
        tag_idx_p[k] <= tag_idx_p[k-1];
      end
    end
  end

  // Return stage: capture ROM data against the oldest tag
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      rdata  <= '0;
      rvalid <= '0;
    end else begin
      rvalid <= '0;
      if (tag_vld_p[ROM_LAT-1]) begin
        rvalid <= idx_onehot(tag_idx_p[ROM_LAT-1]);
        rdata  <= rom_q;
      end
    end
  end

  assign busy = (|req) | (|tag_vld_p);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: a cycle-by-cycle vector table on a
// ROM_LAT=1 instance plus hand-written reset and ROM_LAT=3 sequences.
module tb_sprite_rom_arbiter;

  localparam logic [18:0] A0 = 19'h00003;
  localparam logic [18:0] A1 = 19'h00202;
  localparam logic [18:0] A2 = 19'h00100;
  localparam logic [18:0] A3 = 19'h00307;

  logic        vga_clk = 1'b0;
  logic        Reset;
  logic [3:0]  req, gnt, rvalid;
  logic [75:0] req_addr;
  logic [18:0] rom_address;
  logic [2:0]  rom_q, rdata;
  logic        busy;

  logic [3:0]  req3, gnt3, rvalid3;
  logic [75:0] req_addr3;
  logic [18:0] rom_address3, a_d1, a_d2;
  logic [2:0]  rom_q3, rdata3;
  logic        busy3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 vga_clk = ~vga_clk;

  function automatic logic [2:0] rom_fn(input logic [18:0] a);
    return a[2:0] ^ a[10:8] ^ 3'd5;
  endfunction

  // ROM models: latency 1 reads the current address, latency 3 a twice-delayed one
  assign rom_q = rom_fn(rom_address);
  always @(posedge vga_clk) begin
    a_d1 <= rom_address3;
    a_d2 <= a_d1;
  end
  assign rom_q3 = rom_fn(a_d2);

  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(19), .DATA_W(3), .ROM_LAT(1)) dut (
    .vga_clk     (vga_clk),
    .Reset       (Reset),
    .req         (req),
    .req_addr    (req_addr),
    .gnt         (gnt),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .busy        (busy)
  );

  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(19), .DATA_W(3), .ROM_LAT(3)) dut_lat3 (
    .vga_clk     (vga_clk),
    .Reset       (Reset),
    .req         (req3),
    .req_addr    (req_addr3),
    .gnt         (gnt3),
    .rom_address (rom_address3),
    .rom_q       (rom_q3),
    .rdata       (rdata3),
    .rvalid      (rvalid3),
    .busy        (busy3)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [3:0]  rv;
    logic [2:0]  rd;
    logic [18:0] addr;
    logic        busy;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge vga_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //          req      gnt      rvalid   rd    rom_address busy
    tbl[0]  = '{4'b0100, 4'b0100, 4'b0000, 3'd0, 19'h0,  1'b1};
    tbl[1]  = '{4'b0000, 4'b0000, 4'b0000, 3'd0, A2,     1'b1};
    tbl[2]  = '{4'b0000, 4'b0000, 4'b0100, 3'd4, A2,     1'b0};
    tbl[3]  = '{4'b1000, 4'b1000, 4'b0000, 3'd4, A2,     1'b1};
    tbl[4]  = '{4'b1111, 4'b0001, 4'b0000, 3'd4, A3,     1'b1};
    tbl[5]  = '{4'b1111, 4'b0010, 4'b1000, 3'd1, A0,     1'b1};
    tbl[6]  = '{4'b1111, 4'b0100, 4'b0001, 3'd6, A1,     1'b1};
    tbl[7]  = '{4'b1111, 4'b1000, 4'b0010, 3'd5, A2,     1'b1};
    tbl[8]  = '{4'b1111, 4'b0001, 4'b0100, 3'd4, A3,     1'b1};
    tbl[9]  = '{4'b1111, 4'b0010, 4'b1000, 3'd1, A0,     1'b1};
    tbl[10] = '{4'b1111, 4'b0100, 4'b0001, 3'd6, A1,     1'b1};
    tbl[11] = '{4'b1111, 4'b1000, 4'b0010, 3'd5, A2,     1'b1};
    tbl[12] = '{4'b1010, 4'b0010, 4'b0100, 3'd4, A3,     1'b1};
    tbl[13] = '{4'b1010, 4'b1000, 4'b1000, 3'd1, A1,     1'b1};
    tbl[14] = '{4'b1010, 4'b0010, 4'b0010, 3'd5, A3,     1'b1};
    tbl[15] = '{4'b1010, 4'b1000, 4'b1000, 3'd1, A1,     1'b1};
    tbl[16] = '{4'b0000, 4'b0000, 4'b0010, 3'd5, A3,     1'b1};
    tbl[17] = '{4'b0000, 4'b0000, 4'b1000, 3'd1, A3,     1'b0};
    tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 3'd1, A3,     1'b0};
    tbl[19] = '{4'b0110, 4'b0010, 4'b0000, 3'd1, A3,     1'b1};
    tbl[20] = '{4'b0001, 4'b0001, 4'b0000, 3'd1, A1,     1'b1};
    tbl[21] = '{4'b0000, 4'b0000, 4'b0010, 3'd5, A0,     1'b1};
    tbl[22] = '{4'b0000, 4'b0000, 4'b0001, 3'd6, A0,     1'b0};
    tbl[23] = '{4'b0000, 4'b0000, 4'b0000, 3'd6, A0,     1'b0};

    Reset     = 1'b1;
    req       = 4'b0110;
    req_addr  = {A3, A2, A1, A0};
    req3      = 4'b0000;
    req_addr3 = {A3, A2, A1, A0};

    // Values while reset is held
    @(negedge vga_clk);
    chk("reset gnt from ptr0", 32'(gnt), 32'(4'b0010));
    chk("reset rvalid", 32'(rvalid), 32'd0);
    chk("reset rdata", 32'(rdata), 32'd0);
    chk("reset rom_address", 32'(rom_address), 32'd0);
    chk("reset busy with req", 32'(busy), 32'd1);
    chk("reset lat3 busy", 32'(busy3), 32'd0);
    req = 4'b0000;
    #1;
    chk("reset busy idle", 32'(busy), 32'd0);
    next_cycle();
    Reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      req = tbl[i].req;
      @(negedge vga_clk);
      chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("row%0d rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
      chk($sformatf("row%0d rdata", i), 32'(rdata), 32'(tbl[i].rd));
      chk($sformatf("row%0d rom_address", i), 32'(rom_address), 32'(tbl[i].addr));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      next_cycle();
    end

    // Requester 0 streams addresses 0..3 back-to-back
    for (int k = 0; k < 7; k++) begin
      req = (k < 4) ? 4'b0001 : 4'b0000;
      req_addr[18:0] = (k < 4) ? 19'(k) : A0;
      @(negedge vga_clk);
      chk($sformatf("stream%0d gnt", k), 32'(gnt), (k < 4) ? 32'd1 : 32'd0);
      if (k >= 2 && k < 6) begin
        chk($sformatf("stream%0d rvalid", k), 32'(rvalid), 32'd1);
        chk($sformatf("stream%0d rdata", k), 32'(rdata), 32'(rom_fn(19'(k - 2))));
      end else begin
        chk($sformatf("stream%0d rvalid", k), 32'(rvalid), 32'd0);
      end
      next_cycle();
    end
    req_addr[18:0] = A0;

    // Reset one cycle after a grant to requester 3 discards the read
    req = 4'b1000;
    @(negedge vga_clk);
    chk("rst3 gnt", 32'(gnt), 32'(4'b1000));
    next_cycle();
    req   = 4'b0000;
    Reset = 1'b1;
    @(negedge vga_clk);
    chk("rst3 rvalid in reset", 32'(rvalid), 32'd0);
    chk("rst3 busy in reset", 32'(busy), 32'd0);
    next_cycle();
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge vga_clk);
      chk($sformatf("rst3 post%0d rvalid", k), 32'(rvalid), 32'd0);
      chk($sformatf("rst3 post%0d rdata", k), 32'(rdata), 32'd0);
      next_cycle();
    end
    req = 4'b1001;
    @(negedge vga_clk);
    chk("rst3 next gnt", 32'(gnt), 32'(4'b0001));
    next_cycle();
    req = 4'b0000;
    @(negedge vga_clk);
    chk("rst3 next rvalid early", 32'(rvalid), 32'd0);
    next_cycle();
    @(negedge vga_clk);
    chk("rst3 next rvalid", 32'(rvalid), 32'(4'b0001));
    chk("rst3 next rdata", 32'(rdata), 32'd6);
    next_cycle();

    // Reset restores the pointer to 0 even when it had advanced
    req = 4'b0010;
    @(negedge vga_clk);
    chk("ptr rst gnt1", 32'(gnt), 32'(4'b0010));
    next_cycle();
    req   = 4'b0000;
    Reset = 1'b1;
    next_cycle();
    Reset = 1'b0;
    req   = 4'b0110;
    @(negedge vga_clk);
    chk("ptr rst restart", 32'(gnt), 32'(4'b0010));
    next_cycle();
    req = 4'b0000;

    // ROM_LAT=3 instance: results four cycles after each grant, in order
    for (int j = 0; j < 9; j++) begin
      logic [3:0] eg, erv;
      eg  = (j < 4) ? ((j % 2 == 0) ? 4'b0001 : 4'b0010) : 4'b0000;
      erv = (j >= 4 && j < 8) ? ((j % 2 == 0) ? 4'b0001 : 4'b0010) : 4'b0000;
      req3 = (j < 4) ? 4'b0011 : 4'b0000;
      @(negedge vga_clk);
      chk($sformatf("lat3 c%0d gnt", j), 32'(gnt3), 32'(eg));
      chk($sformatf("lat3 c%0d rvalid", j), 32'(rvalid3), 32'(erv));
      if (j >= 4 && j < 8)
        chk($sformatf("lat3 c%0d rdata", j), 32'(rdata3), (j % 2 == 0) ? 32'd6 : 32'd5);
      if (j == 6) chk("lat3 busy draining", 32'(busy3), 32'd1);
      if (j == 7) chk("lat3 busy drained", 32'(busy3), 32'd0);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of sprite requesters (paddles, ball, score).
REQ-002 Parameter ADDR_W, default 19, ROM address width.
REQ-003 Parameter DATA_W, default 3, ROM palette-index width.
REQ-004 Parameter ROM_LAT, default 1, ROM read latency in cycles from rom_address update to valid rom_q (1..4).
REQ-005 vga_clk  input  1  sole clock; all state on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 req  input  N_REQ  per-requester read request; held until granted.
REQ-008 req_addr  input  N_REQ*ADDR_W  packed addresses; requester i in bits [i*ADDR_W +: ADDR_W].
REQ-009 gnt  output  N_REQ  one-hot combinational grant for the current cycle.
REQ-010 rom_address  output  ADDR_W  registered address to the shared sprite ROM.
REQ-011 rom_q  input  DATA_W  ROM read data.
REQ-012 rdata  output  DATA_W  registered return data, shared by all requesters.
REQ-013 rvalid  output  N_REQ  registered one-hot qualifier for rdata.
REQ-014 busy  output  1  high when any req is asserted or any read is in flight.

Function
REQ-015 Each cycle, gnt SHALL be zero when req is zero; otherwise exactly one bit SHALL be set, selecting the first asserted requester when searching from index ptr upward with wrap to 0.
REQ-016 gnt[i] SHALL only be asserted when req[i] is asserted in the same cycle.
REQ-017 On a grant to i in cycle T, ptr SHALL become (i+1) mod N_REQ at the end of T; with no grant, ptr SHALL hold.
REQ-018 On a grant to i in cycle T, rom_address SHALL load req_addr[i] at the end of T; with no grant, rom_address SHALL hold its last value.
REQ-019 A tag pipeline (valid bit plus requester index) SHALL track each grant so that rvalid[i] is high in exactly cycle T+ROM_LAT+1, with rdata equal to rom_q for that address.
REQ-020 When no result is due, rvalid SHALL be all-zero and rdata SHALL hold its last value.
REQ-021 Throughput SHALL be one grant per cycle, with no bubbles between back-to-back grants, including repeated grants to the same requester.
REQ-022 A requester seeing gnt[i] in cycle T MAY present a new address and keep req asserted in T+1; that request SHALL be eligible immediately.
REQ-023 Dropping req[i] without a grant SHALL have no side effects.
REQ-024 Results SHALL return in grant order, and rvalid SHALL never be asserted for more than one requester in a cycle.
REQ-025 busy SHALL equal (|req) OR (any tag-pipeline valid bit).

Reset
REQ-026 While Reset is high: ptr=0, rom_address=0, rdata=0, rvalid=0, and all tag valid bits are cleared; gnt still follows REQ-015 from ptr=0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight reads; no rvalid SHALL be produced for grants issued before reset.
REQ-028 The first grant after Reset deassertion SHALL search from requester 0.

Structure
REQ-029 Package sprite_arb_pkg SHALL hold default N_REQ/ADDR_W/DATA_W/ROM_LAT localparams and the requester-index typedef (width $clog2(N_REQ)).
REQ-030 Sub-module rr_priority_pick (combinational; inputs req and ptr; outputs one-hot gnt, granted index and any_gnt) SHALL implement REQ-015.
REQ-031 The ROM and palette SHALL remain outside this block.

Verification
REQ-032 Scenario: only req[2], addr 0x00100, ROM_LAT=1 -> gnt=4'b0100 in T; rom_address=0x00100 from T+1; rvalid=4'b0100 in T+2 with rdata equal to the ROM model value.
REQ-033 Scenario: req=4'b1111 held for 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3; rvalid follows the same sequence 2 cycles later.
REQ-034 Scenario: req=4'b1010 held, ptr=0 -> grants 1,3,1,3; requesters 0 and 2 never granted.
REQ-035 Scenario: single requester 0 issuing addresses 0,1,2,3 back-to-back -> four consecutive grants and four consecutive rvalid=4'b0001 with matching rdata.
REQ-036 Scenario: Reset pulsed one cycle after a grant to requester 3 -> no rvalid appears; the next grant with req=4'b1001 goes to requester 0.
REQ-037 Scenario: ROM_LAT=3, req=4'b0011 -> rvalid for each grant appears exactly 4 cycles after it, in grant order.
